// File: rtl/single_port_ram_wr_ctrl.sv
// single_port_ram_wr_ctrl: burst writer into a single-port RAM (din valid/ready in, done/wr_count out) with an idle-time registered read port
module single_port_ram_wr_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_w,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_WORDS - 1);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0] r_count;
  logic [DATA_W-1:0] r_rd;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic w_beat, w_last;
  logic [ADDR_W-1:0] w_ram_addr;
  assign w_beat = r_state == WRITE && din_valid;
  assign w_last = w_beat && r_count == LAST;
  assign w_ram_addr = r_state == WRITE ? r_addr : rd_addr;
  always_comb
    w_next = r_state == IDLE ? (start_w ? WRITE : IDLE) : r_state == WRITE ? (w_last ? DONE : WRITE) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_count <= '0;
      r_rd <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start_w) begin
        r_addr <= '0;
        r_count <= '0;
      end else if (w_beat) begin
        r_addr <= r_addr + 1'b1;
        r_count <= r_count + 1'b1;
      end
      if (r_state == IDLE) r_rd <= r_mem[w_ram_addr];
    end
  always_ff @(posedge clk)
    if (w_beat) r_mem[w_ram_addr] <= din;
  assign din_ready = r_state == WRITE;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign wr_count = r_count;
  assign rd_data = r_rd;
endmodule

// File: tb/tb_single_port_ram_wr_ctrl.sv
// tb_single_port_ram_wr_ctrl: scoreboard bench for a 16-word and a 4-word instance against a word-array model
module tb_single_port_ram_wr_ctrl;
  localparam int DW = 16, AW = 4, DEPTH = 16;
  typedef struct {int c; int n;} done_t;
  typedef struct {bit s; logic [DW-1:0] v;} rd_t;
  logic clk = 0, rst = 1, start_w = 0, din_valid = 0, sel = 0, rd_req = 0;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] rd_addr = '0;
  logic a_ready, a_busy, a_done, b_ready, b_busy, b_done;
  logic [AW:0] a_cnt, b_cnt;
  logic [DW-1:0] a_rd, b_rd;
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  done_t dqa[$], dqb[$];
  rd_t rq[$];
  int vectors = 0, errors = 0, cyc = 0;
  bit pend = 0;
  rd_t mr;
  done_t md;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  single_port_ram_wr_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(16)) dut_a (
    .clk(clk), .rst(rst), .start_w(start_w & ~sel), .din(din), .din_valid(din_valid & ~sel),
    .din_ready(a_ready), .busy(a_busy), .done(a_done), .wr_count(a_cnt), .rd_addr(rd_addr), .rd_data(a_rd));
  single_port_ram_wr_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(4)) dut_b (
    .clk(clk), .rst(rst), .start_w(start_w & sel), .din(din), .din_valid(din_valid & sel),
    .din_ready(b_ready), .busy(b_busy), .done(b_done), .wr_count(b_cnt), .rd_addr(rd_addr), .rd_data(b_rd));
  function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
    end
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (pend) begin
      if (rq.size() == 0) chk("rd_queue_empty", 1, 0);
      else begin
        mr = rq.pop_front();
        chk(mr.s ? "rd_data_b" : "rd_data_a", mr.s ? b_rd : a_rd, mr.v);
      end
    end
    pend = rd_req;
    if (a_done === 1'b1) begin
      if (dqa.size() == 0) chk("spurious_done_a", 1, 0);
      else begin
        md = dqa.pop_front();
        chk("done_cycle_a", cyc, md.c);
        chk("done_count_a", a_cnt, md.n);
      end
    end
    if (b_done === 1'b1) begin
      if (dqb.size() == 0) chk("spurious_done_b", 1, 0);
      else begin
        md = dqb.pop_front();
        chk("done_cycle_b", cyc, md.c);
        chk("done_count_b", b_cnt, md.n);
      end
    end
  end
  task automatic burst(input bit s, input int n, input int mode, input logic [DW-1:0] base,
                       input logic [DW-1:0] step, input bit rnd, input int ghost, input int abort_at);
    int e, k, j;
    bit v;
    logic [DW-1:0] d;
    done_t t;
    sel = s;
    start_w = 1;
    din_valid = 1'($urandom);
    e = cyc + 1;
    tick();
    chk("ready_in_write", s ? b_ready : a_ready, 1);
    chk("busy_in_write", s ? b_busy : a_busy, 1);
    chk("count_cleared", s ? b_cnt : a_cnt, 0);
    k = 0;
    j = 0;
    while (k < n) begin
      j++;
      v = mode == 0 ? 1'b1 : mode == 1 ? (j % 2 == 1) : ($urandom_range(0, 2) != 0);
      d = rnd ? DW'($urandom) : DW'(base + step * DW'(k));
      din_valid = v;
      din = v ? d : DW'($urandom);
      start_w = (k == ghost);
      rd_addr = AW'($urandom);
      tick();
      if (v) begin
        if (s) mem_b[k] = d; else mem_a[k] = d;
        k++;
      end
      chk("wr_count_beat", s ? b_cnt : a_cnt, k);
      if (abort_at >= 0 && k == abort_at) begin
        rst = 1;
        din_valid = 0;
        start_w = 0;
        #1;
        chk("abort_ready", s ? b_ready : a_ready, 0);
        chk("abort_busy", s ? b_busy : a_busy, 0);
        chk("abort_done", s ? b_done : a_done, 0);
        chk("abort_count", s ? b_cnt : a_cnt, 0);
        chk("abort_rd", s ? b_rd : a_rd, 0);
        tick();
        rst = 0;
        tick();
        return;
      end
    end
    t.c = e + j;
    t.n = n;
    if (s) dqb.push_back(t); else dqa.push_back(t);
    din_valid = 1'($urandom);
    start_w = 1'($urandom);
    chk("busy_in_done", s ? b_busy : a_busy, 1);
    chk("ready_in_done", s ? b_ready : a_ready, 0);
    tick();
    start_w = 0;
    din_valid = 0;
    chk("busy_idle", s ? b_busy : a_busy, 0);
    chk("ready_idle", s ? b_ready : a_ready, 0);
  endtask
  task automatic rd(input bit s, input int a);
    rd_t r;
    sel = s;
    rd_addr = AW'(a);
    rd_req = 1;
    r.s = s;
    r.v = s ? mem_b[a] : mem_a[a];
    rq.push_back(r);
    tick();
  endtask
  task automatic rd_end();
    rd_req = 0;
    tick();
    tick();
  endtask
  initial begin
    start_w = 1'($urandom);
    din_valid = 1'($urandom);
    din = DW'($urandom);
    rd_addr = AW'($urandom);
    tick();
    chk("rst_ready_a", a_ready, 0);
    chk("rst_busy_a", a_busy, 0);
    chk("rst_done_a", a_done, 0);
    chk("rst_count_a", a_cnt, 0);
    chk("rst_rd_a", a_rd, 0);
    chk("rst_ready_b", b_ready, 0);
    chk("rst_busy_b", b_busy, 0);
    chk("rst_done_b", b_done, 0);
    chk("rst_count_b", b_cnt, 0);
    chk("rst_rd_b", b_rd, 0);
    rst = 0;
    start_w = 0;
    din_valid = 0;
    tick();
    for (int a = 4; a < DEPTH; a++) begin
      sel = 1;
      rd_addr = AW'(a);
      tick();
      mem_b[a] = b_rd;
    end
    burst(0, 16, 0, 16'hA000, 16'd1, 0, -1, -1);
    for (int a = 0; a < DEPTH; a++) rd(0, a);
    rd_end();
    burst(0, 16, 1, 16'h5A00, 16'd1, 0, -1, -1);
    for (int a = 0; a < DEPTH; a++) rd(0, a);
    rd_end();
    burst(0, 16, 0, 16'hC300, 16'd3, 0, 7, -1);
    for (int a = 0; a < DEPTH; a++) rd(0, a);
    rd_end();
    burst(0, 16, 0, 16'h1110, 16'd1, 0, -1, 5);
    for (int a = 0; a < 6; a++) rd(0, a);
    rd_end();
    burst(1, 4, 0, 16'hFFFF, 16'd0, 0, -1, -1);
    burst(1, 4, 0, 16'h0001, 16'd1, 0, -1, -1);
    for (int a = 0; a < DEPTH; a++) rd(1, a);
    rd_end();
    for (int r = 0; r < 10; r++) begin
      bit s;
      s = 1'($urandom);
      burst(s, s ? 4 : 16, 2, 16'h0, 16'h0, 1, $urandom_range(0, 3), -1);
      for (int i = 0; i < 6; i++) rd(1'($urandom), $urandom_range(0, DEPTH - 1));
      rd_end();
    end
    repeat (3) tick();
    chk("missing_done_a", dqa.size(), 0);
    chk("missing_done_b", dqb.size(), 0);
    chk("missing_reads", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
